// File: rtl/readout_pkg.sv
// readout_pkg: shared FSM state type, tag width and frame-width helper (frame widens when SAMPLE_TAG_EN is defined)
package readout_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int TAG_W = 4;
  function automatic int frame_w(input int data_w);
`ifdef SAMPLE_TAG_EN
    return data_w + TAG_W;
`else
    return data_w;
`endif
  endfunction
endpackage

// File: rtl/sample_sync_fifo.sv
// sample_sync_fifo: synchronous FIFO; ports clk, rst, push, pop, wr_data in; rd_data (combinational head), count, full, empty out; a push while full is accepted only alongside a pop
module sample_sync_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/sample_readout_serializer.sv
// sample_readout_serializer: buffers filter samples (clk, rst, data_in, new_data, enable, clr_ovf in) and sends them as framed MSB-first serial words (sclk_out, sdo, frame, fifo_count, overflow out); SAMPLE_TAG_EN prepends a 4-bit sequence tag
module sample_readout_serializer
  import readout_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   new_data,
  input  logic                   enable,
  input  logic                   clr_ovf,
  output logic                   sclk_out,
  output logic                   sdo,
  output logic                   frame,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int FRAME_W = frame_w(DATA_W);
  localparam int BW = $clog2(FRAME_W);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  state_t state;
  logic [FRAME_W-1:0] wr_data, rd_data, sreg;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] phase;
  logic full, empty, pop, drop;
  assign pop = state == IDLE && enable && !empty;
  assign drop = new_data && full && !pop;
`ifdef SAMPLE_TAG_EN
  logic [TAG_W-1:0] seq;
  always_ff @(posedge clk)
    if (rst) seq <= '0;
    else if (new_data) seq <= seq + 1'b1;
  assign wr_data = {seq, data_in};
`else
  assign wr_data = data_in;
`endif
  sample_sync_fifo #(.W(FRAME_W), .DEPTH(DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(new_data), .pop(pop), .wr_data(wr_data),
    .rd_data(rd_data), .count(fifo_count), .full(full), .empty(empty)
  );
  // sreg holds the bits still to be sent; outputs are registered one cycle ahead of the phase they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      phase <= '0;
      sclk_out <= 1'b0;
      sdo <= 1'b0;
      frame <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
      case (state)
        IDLE:
          if (pop) begin
            state <= SHIFT;
            sreg <= rd_data << 1;
            sdo <= rd_data[FRAME_W-1];
            frame <= 1'b1;
            bit_cnt <= '0;
            phase <= '0;
            sclk_out <= 1'b0;
          end
        SHIFT:
          if (phase != PH_LAST) begin
            phase <= phase + 1'b1;
            sclk_out <= phase >= PH_HALF;
          end else if (bit_cnt == BIT_LAST) begin
            state <= GAP;
            phase <= '0;
            sclk_out <= 1'b0;
            sdo <= 1'b0;
            frame <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            phase <= '0;
            sclk_out <= 1'b0;
            sdo <= sreg[FRAME_W-1];
            sreg <= sreg << 1;
          end
        GAP: begin
          phase <= phase == PH_LAST ? '0 : phase + 1'b1;
          state <= phase == PH_LAST ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sample_readout_serializer.md
Name: sample_readout_serializer

Overview:
- Stage directly downstream of digital_filter.
- Captures each 12-bit decimated sample strobed by the filter's new_data pulse into a small synchronous FIFO.
- Drains the FIFO over a framed, MSB-first serial link (sdo/sclk_out/frame) to the off-chip reader.
- Reports FIFO occupancy and a sticky overflow flag.

Parameters:
- DATA_W, 12, sample width; matches the filter's data_out.
- DEPTH, 8, FIFO entries; power of 2, >= 2.
- CLK_DIV, 4, clk cycles per serial bit; even, >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  sample from the filter; qualified by new_data.
- new_data  in  1  one-cycle sample strobe from the filter.
- enable  in  1  permits starting new frames.
- clr_ovf  in  1  clears overflow.
- sclk_out  out  1  serial bit clock.
- sdo  out  1  serial data, MSB first.
- frame  out  1  high for the whole data portion of a frame.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a sample was dropped.

Behaviour:
- Reset, sampled on a rising clk edge:
  - FIFO emptied; fifo_count=0.
  - State IDLE; sclk_out=0, sdo=0, frame=0, overflow=0.
  - Bit and phase counters 0.
- Push: new_data=1 at an edge writes data_in if count<DEPTH, or if a pop occurs at the same edge.
  - Otherwise the sample is dropped and overflow is set.
  - fifo_count reflects the push one cycle later.
- Overflow flag:
  - clr_ovf clears it; a set at the same edge wins over clr_ovf.
- Frame width: FRAME_W = DATA_W, or DATA_W+4 with the optional feature.
- FSM states and transitions:
  - IDLE: if enable=1 and count>0, pop the head into the shift register and go to SHIFT. Pop and push in the same cycle are both legal, with count unchanged.
  - SHIFT: frame=1. Each bit lasts CLK_DIV cycles. sdo is updated on the first cycle of a bit. sclk_out=0 for the first CLK_DIV/2 cycles and 1 for the rest, so the reader samples on the sclk_out rising edge. After FRAME_W bits, go to GAP.
  - GAP: CLK_DIV cycles with frame=0, sdo=0, sclk_out=0, then IDLE.
- Timing:
  - First sdo bit and frame rise on the cycle after the pop edge.
  - Minimum frame-start spacing is (FRAME_W+1)*CLK_DIV+1 cycles: 53 cycles at the defaults. This is well under the filter's output period.
- enable dropped mid-frame: the current frame and its GAP complete; no further pop occurs.
- Reset mid-frame: the frame is aborted immediately and outputs return to reset values on the next cycle.
- Data arriving while the FIFO is empty and the FSM is IDLE is not bypassed: it goes through the FIFO (push edge, then pop edge).

Optional Feature:
- Macro: SAMPLE_TAG_EN.
- When defined:
  - A 4-bit sequence counter (reset 0) increments on every new_data pulse, including dropped ones.
  - The counter's pre-increment value is stored with each sample, making FIFO entries DATA_W+4 wide.
  - Frames carry the tag in the top 4 bits, followed by the sample (FRAME_W=16), so the reader can detect gaps.
- When undefined: no counter, FIFO width is DATA_W, FRAME_W=DATA_W.

Decomposition:
- Package readout_pkg holds:
  - state enum {IDLE, SHIFT, GAP};
  - TAG_W=4;
  - a FRAME_W function of DATA_W and the macro.
- Sub-module sample_sync_fifo:
  - parameterised width and depth;
  - push, pop, rd_data (head, combinational), count, full, empty;
  - synchronous active-high reset.
- FSM and shifter live in the top module.

Test Plan:
- Single sample: push 0xA5C, enable=1.
  - frame high for 48 cycles.
  - sdo reads 1010_0101_1100 on the sclk_out rising edges.
  - fifo_count goes 0->1->0.
  - overflow=0.
- Burst, with enable=0: push 9 samples 0x001..0x009 on consecutive cycles.
  - fifo_count saturates at 8 and overflow=1.
  - After enable=1, exactly 0x001..0x008 are emitted, in order.
- Simultaneous events:
  - FIFO full with FSM IDLE; assert enable together with a new_data push on the pop edge. The push is accepted, count stays 8 and overflow stays 0.
  - clr_ovf with a concurrent drop leaves overflow=1.
- enable deassertion: deassert enable mid-frame.
  - The frame completes all 12 bits and GAP.
  - The next sample stays queued until enable returns.
- Reset mid-SHIFT:
  - frame, sdo, sclk_out, fifo_count, overflow are all 0 on the next cycle.
  - A fresh push then transmits normally.
- SAMPLE_TAG_EN defined: 3 pushes with the 2nd dropped by a full FIFO.
  - Emitted tags skip a value.
  - Frames are 16 bits (64 cycles).
